mii_rx_frame: RTL
=================

Name: mii_rx_frame

Overview:
- Receive-side counterpart of the MII frame transmitter. Consumes 100BASE-T MII nibbles from the PHY and strips preamble/SFD.
- Filters on destination MAC and EtherType, captures header fields, and packs payload bytes into 32-bit words for downstream logic.
- Ends every frame with a one-cycle status (good/error). Sits between the PHY receive pins and the debug/trace consumer in fpga_core.

Parameters:
- MAC_ADDR, 48'h8F54_0000_1654, local station address accepted as destination.
- ETH_TYPE, 16'h005c, only EtherType accepted.
- MAX_BYTES, 1518, max bytes after SFD (header+payload+FCS); longer frames are errored.
- MIN_BYTES, 64, min bytes after SFD; shorter frames are runts.
- PROMISC, 1'b0, 1 = accept any destination MAC and EtherType.

Ports:
- clk  in  1  PHY receive clock (board phy_rx_clk, 25 MHz); sole clock.
- rst  in  1  reset, asynchronous, active-high.
- phy_rxd  in  4  MII receive nibble.
- phy_rx_dv  in  1  receive data valid.
- phy_rx_er  in  1  receive error.
- rx_data  out  32  payload word; first byte in [7:0].
- rx_valid  out  1  rx_data valid, one-cycle pulse per word; no backpressure.
- rx_last  out  1  with rx_valid: final payload word of the frame.
- rx_keep  out  4  byte enables for rx_data; 4'hF except possibly on rx_last.
- rx_done  out  1  one-cycle end-of-frame status strobe.
- rx_good  out  1  valid with rx_done: frame accepted with no error.
- rx_err  out  3  valid with rx_done: {crc, length, phy/align}.
- rx_src_mac  out  48  source MAC of the last accepted frame; updated at header end.
- rx_eth_type  out  16  EtherType of the last accepted frame.

Behaviour:
- Reset: all outputs 0, state IDLE. rst mid-frame aborts immediately with no rx_done. The next frame is recognised only after dv has been low for at least 1 cycle.
- Nibble order: low nibble first. A byte completes on the 2nd nibble.
- States:
  - IDLE: dv=1 and rxd=5 -> PRE.
  - PRE: rxd=5 stay. rxd=D after at least 1 preamble nibble -> HDR, byte count=0. Any other nibble, or dv=0 -> DROP/IDLE.
  - HDR: bytes 0..13. dst = bytes 0-5, src = 6-11, type = 12-13 (byte 12 is the MSB).
    - Destination mismatch (not MAC_ADDR, not all-ones, PROMISC=0) at byte 5 -> DROP.
    - Type mismatch at byte 13 -> DROP.
    - Otherwise latch rx_src_mac and rx_eth_type -> PAY.
  - PAY: bytes enter a 4-byte FCS delay line. A byte is packed into the word register only after it leaves the delay line, so the FCS is never emitted.
  - DROP: ignore input until dv=0 -> IDLE. No words and no rx_done.
  - END: entered on dv falling in PAY. Flush the pending word, emit rx_done for 1 cycle, then go to IDLE.
- Word output:
  - A completed word is held as "pending".
  - It is emitted with rx_last=0 when the next payload byte is packed.
  - It is emitted with rx_last=1 at END.
  - A partial final word gets rx_keep = ones for the valid low bytes.
  - At END, rx_valid/rx_last and rx_done occur in the same cycle.
  - Zero payload bytes: no rx_valid, only rx_done.
- Errors (frame continues to END; words already emitted stand; downstream discards on rx_good=0):
  - phy_rx_er=1 in HDR/PAY, or dv falling after an odd nibble -> err[0].
  - Byte count < MIN_BYTES or > MAX_BYTES -> err[1]. At MAX_BYTES+1, stop emitting words and wait for dv=0.
  - CRC failure -> err[2] (see Optional Feature).
- rx_good = (rx_err == 0).
- Widths: byte counter 11 bits, saturating.

Optional Feature:
- Macro: MII_RX_CRC_EN.
- Defined: CRC-32 (reflected, poly 0x04C11DB7, init all-ones), updated per byte over all bytes after SFD including the FCS.
  - At END, residue != 32'hC704DD7B sets rx_err[2].
- Undefined: no CRC logic; rx_err[2] is tied to 0. The FCS is still stripped.

Decomposition:
- Package mii_rx_pkg:
  - state enum typedef.
  - constants: SFD nibble 4'hD, preamble nibble 4'h5, HDR_BYTES=14, FCS_BYTES=4, CRC_RESIDUE, rx_err bit indices.
- Sub-module crc32_byte: combinational next-CRC from {crc, byte}. Instantiated only under MII_RX_CRC_EN.

Test Plan:
- Good frame: 7×55+D5, dst=MAC_ADDR, type 005c, 48 payload bytes 00..2F, correct FCS -> 12 words.
  - Word 0 = 32'h03020100; last word = 32'h2F2E2D2C, keep F, rx_last=1.
  - rx_done with rx_good=1, rx_err=0.
- Odd payload (50 bytes): last word keep=4'b0011, data[15:0]=16'h3130, rx_good=1.
- Wrong dst 48'h0000_0000_0001 -> no rx_valid, no rx_done. A broadcast dst frame that follows is accepted.
- phy_rx_er pulsed at payload byte 10 -> words still emitted, then rx_done with rx_err=3'b001.
- Corrupted FCS byte -> rx_err=3'b100 when MII_RX_CRC_EN is defined; 3'b000 and rx_good=1 when undefined.
- 40-byte frame -> rx_err[1]=1. rst asserted mid-payload -> outputs 0, no rx_done; the next frame is received normally.

Source files
------------

// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII receive frame path.
package mii_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_DROP,
        ST_END
    } state_t;

    localparam logic [3:0]  PRE_NIB     = 4'h5;
    localparam logic [3:0]  SFD_NIB     = 4'hD;
    localparam int unsigned DST_LAST    = 5;
    localparam int unsigned HDR_BYTES   = 14;
    localparam int unsigned FCS_BYTES   = 4;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    localparam int unsigned ERR_PHY = 0;
    localparam int unsigned ERR_LEN = 1;
    localparam int unsigned ERR_CRC = 2;

    function automatic logic [3:0] keep_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        return {<<{v}};
    endfunction

endpackage

// File: rtl/mii_rx_frame_crc32_byte.sv
// Combinational reflected CRC-32 (poly 0x04C11DB7) update over one byte.
// Only instantiated when MII_RX_CRC_EN is defined.
module crc32_byte (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx_frame.sv
// MII receive framer: strips preamble/SFD, filters dst MAC and EtherType, packs payload
// into 32-bit words with the FCS withheld. Define MII_RX_CRC_EN to enable FCS checking.
module mii_rx_frame
    import mii_rx_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h8F54_0000_1654,
    parameter logic [15:0] ETH_TYPE  = 16'h005c,
    parameter int unsigned MAX_BYTES = 1518,
    parameter int unsigned MIN_BYTES = 64,
    parameter bit          PROMISC   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  phy_rxd,
    input  logic        phy_rx_dv,
    input  logic        phy_rx_er,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_last,
    output logic [3:0]  rx_keep,
    output logic        rx_done,
    output logic        rx_good,
    output logic [2:0]  rx_err,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_eth_type
);

    localparam logic [10:0] MAX_B = 11'(MAX_BYTES);
    localparam logic [10:0] MIN_B = 11'(MIN_BYTES);

    state_t      state_q, state_d;
    logic        dv_prev_q;
    logic        nib_odd_q, nib_odd_d;
    logic [3:0]  lo_nib_q, lo_nib_d;
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    logic [55:0] sh_q, sh_d;
    logic [31:0] dl_q, dl_d;
    logic [2:0]  dl_cnt_q, dl_cnt_d;
    logic [31:0] wd_q, wd_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [2:0]  err_q, err_d, err_fin;

    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_last_q, rx_last_d;
    logic [3:0]  rx_keep_q, rx_keep_d;
    logic        rx_done_q, rx_done_d;
    logic        rx_good_q, rx_good_d;
    logic [2:0]  rx_err_q, rx_err_d;
    logic [47:0] rx_src_mac_q, rx_src_mac_d;
    logic [15:0] rx_eth_type_q, rx_eth_type_d;

    logic [7:0]  byte_w, pack_b;
    logic        byte_en, dst_ok, type_ok, crc_bad;

    assign byte_w  = {phy_rxd, lo_nib_q};
    assign byte_en = phy_rx_dv && nib_odd_q && (state_q == ST_HDR || state_q == ST_PAY);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;
    assign dst_ok  = PROMISC || ({sh_q[39:0], byte_w} == MAC_ADDR) || ({sh_q[39:0], byte_w} == '1);
    assign type_ok = PROMISC || ({sh_q[7:0], byte_w} == ETH_TYPE);
    assign pack_b  = dl_q[7:0];

`ifdef MII_RX_CRC_EN
    logic [31:0] crc_q, crc_d, crc_nx;

    crc32_byte u_crc (
        .crc_in  (crc_q),
        .data_in (byte_w),
        .crc_out (crc_nx)
    );

    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_PRE) begin
            crc_d = '1;
        end else if (byte_en) begin
            crc_d = crc_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '1;
        else     crc_q <= crc_d;
    end

    // Register holds the reflected CRC; residue constant is in normal bit order.
    assign crc_bad = (bitrev32(crc_q) != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        nib_odd_d     = nib_odd_q;
        lo_nib_d      = lo_nib_q;
        cnt_d         = cnt_q;
        sh_d          = sh_q;
        dl_d          = dl_q;
        dl_cnt_d      = dl_cnt_q;
        wd_d          = wd_q;
        wcnt_d        = wcnt_q;
        err_d         = err_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_last_d     = 1'b0;
        rx_keep_d     = rx_keep_q;
        rx_done_d     = 1'b0;
        rx_good_d     = rx_good_q;
        rx_err_d      = rx_err_q;
        rx_src_mac_d  = rx_src_mac_q;
        rx_eth_type_d = rx_eth_type_q;
        err_fin       = err_q;
        err_fin[ERR_CRC] = crc_bad;

        if ((state_q == ST_HDR || state_q == ST_PAY) && phy_rx_dv) begin
            if (!nib_odd_q) lo_nib_d = phy_rxd;
            nib_odd_d = !nib_odd_q;
            if (phy_rx_er) err_d[ERR_PHY] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Rising dv only: a frame already in flight at reset release is ignored.
                if (phy_rx_dv && !dv_prev_q && phy_rxd == PRE_NIB) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (!phy_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (phy_rxd == SFD_NIB) begin
                    state_d   = ST_HDR;
                    cnt_d     = '0;
                    nib_odd_d = 1'b0;
                    err_d     = '0;
                    dl_cnt_d  = '0;
                    wcnt_d    = '0;
                    wd_d      = '0;
                end else if (phy_rxd != PRE_NIB) begin
                    state_d = ST_DROP;
                end
            end
            ST_HDR: begin
                if (!phy_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (byte_en) begin
                    sh_d  = {sh_q[47:0], byte_w};
                    cnt_d = cnt_inc;
                    if (cnt_q == 11'(DST_LAST) && !dst_ok) state_d = ST_DROP;
                    if (cnt_q == 11'(HDR_BYTES - 1)) begin
                        if (type_ok) begin
                            rx_src_mac_d  = sh_q[55:8];
                            rx_eth_type_d = {sh_q[7:0], byte_w};
                            state_d       = ST_PAY;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_PAY: begin
                if (!phy_rx_dv) begin
                    if (nib_odd_q) err_d[ERR_PHY] = 1'b1;
                    if (cnt_q < MIN_B || cnt_q > MAX_B) err_d[ERR_LEN] = 1'b1;
                    state_d = ST_END;
                end else if (byte_en) begin
                    cnt_d = cnt_inc;
                    dl_d  = {byte_w, dl_q[31:8]};
                    if (cnt_q >= MAX_B) begin
                        // Oversize: discard the partial word so nothing more is emitted.
                        err_d[ERR_LEN] = 1'b1;
                        wcnt_d         = '0;
                    end else if (dl_cnt_q == 3'(FCS_BYTES)) begin
                        if (wcnt_q == 3'd4) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = wd_q;
                            rx_keep_d  = 4'hF;
                            wd_d       = {24'h0, pack_b};
                            wcnt_d     = 3'd1;
                        end else begin
                            case (wcnt_q[1:0])
                                2'd0:    wd_d[7:0]   = pack_b;
                                2'd1:    wd_d[15:8]  = pack_b;
                                2'd2:    wd_d[23:16] = pack_b;
                                default: wd_d[31:24] = pack_b;
                            endcase
                            wcnt_d = wcnt_q + 3'd1;
                        end
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                end
            end
            ST_END: begin
                if (wcnt_q != 3'd0) begin
                    rx_valid_d = 1'b1;
                    rx_last_d  = 1'b1;
                    rx_data_d  = wd_q;
                    rx_keep_d  = keep_mask(wcnt_q);
                end
                rx_done_d = 1'b1;
                rx_err_d  = err_fin;
                rx_good_d = (err_fin == '0);
                state_d   = ST_IDLE;
            end
            ST_DROP: begin
                if (!phy_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dv_prev_q     <= 1'b1;
            nib_odd_q     <= 1'b0;
            lo_nib_q      <= '0;
            cnt_q         <= '0;
            sh_q          <= '0;
            dl_q          <= '0;
            dl_cnt_q      <= '0;
            wd_q          <= '0;
            wcnt_q        <= '0;
            err_q         <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_last_q     <= 1'b0;
            rx_keep_q     <= '0;
            rx_done_q     <= 1'b0;
            rx_good_q     <= 1'b0;
            rx_err_q      <= '0;
            rx_src_mac_q  <= '0;
            rx_eth_type_q <= '0;
        end else begin
            state_q       <= state_d;
            dv_prev_q     <= phy_rx_dv;
            nib_odd_q     <= nib_odd_d;
            lo_nib_q      <= lo_nib_d;
            cnt_q         <= cnt_d;
            sh_q          <= sh_d;
            dl_q          <= dl_d;
            dl_cnt_q      <= dl_cnt_d;
            wd_q          <= wd_d;
            wcnt_q        <= wcnt_d;
            err_q         <= err_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_last_q     <= rx_last_d;
            rx_keep_q     <= rx_keep_d;
            rx_done_q     <= rx_done_d;
            rx_good_q     <= rx_good_d;
            rx_err_q      <= rx_err_d;
            rx_src_mac_q  <= rx_src_mac_d;
            rx_eth_type_q <= rx_eth_type_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_last     = rx_last_q;
    assign rx_keep     = rx_keep_q;
    assign rx_done     = rx_done_q;
    assign rx_good     = rx_good_q;
    assign rx_err      = rx_err_q;
    assign rx_src_mac  = rx_src_mac_q;
    assign rx_eth_type = rx_eth_type_q;

endmodule
